// File: rtl/operation_sched.sv
// Round-robin scheduler sharing one ST/RD/RES operation unit among NREQ requesters.
// Optional watchdog enabled by defining OPSCHED_TIMEOUT_EN.
module operation_sched #(
  parameter int BW   = 16,
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int TMO  = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ*BW-1:0]   REQ_IN0,
  input  logic [NREQ*BW-1:0]   REQ_IN1,
  output logic [NREQ-1:0]      ACK,
  output logic [BW-1:0]        RES_OUT,
  output logic [IDW-1:0]       GNT_ID,
  output logic                 BUSY,
  output logic                 ERR,
  output logic                 OP_ST,
  output logic [BW-1:0]        OP_IN0,
  output logic [BW-1:0]        OP_IN1,
  input  logic                 OP_RD,
  input  logic [BW-1:0]        OP_RES
);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("operation_sched: NREQ must be in 2..8");
  end
  if ((1 << IDW) < NREQ) begin : g_bad_idw
    $error("operation_sched: IDW too narrow for NREQ");
  end
  if (TMO < 1 || TMO > 255) begin : g_bad_tmo
    $error("operation_sched: TMO must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOW  = 2'd1,
    WAIT_HIGH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [BW-1:0]   res_q, res_d;
  logic [IDW-1:0]  gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            st_q, st_d;
  logic [BW-1:0]   in0_q, in0_d;
  logic [BW-1:0]   in1_q, in1_d;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [IDW:0]      win_sum;
  logic [IDW-1:0]    win_id;
  logic              found;
  logic [BW-1:0]     sel0, sel1;
  logic [NREQ-1:0]   gnt_onehot;
  logic [IDW-1:0]    ptr_next;
  logic              expire;

  // Rotate requests so bit 0 is the pointer position; first set bit wins.
  always_comb begin
    req_dbl = {REQ, REQ} >> ptr_q;
    req_rot = req_dbl[NREQ-1:0];
    found   = 1'b0;
    win_sum = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && req_rot[k]) begin
        found   = 1'b1;
        win_sum = {1'b0, ptr_q} + (IDW+1)'(k);
      end
    end
    if (win_sum >= (IDW+1)'(NREQ)) begin
      win_sum = win_sum - (IDW+1)'(NREQ);
    end
    win_id = win_sum[IDW-1:0];
  end

  always_comb begin
    sel0       = '0;
    sel1       = '0;
    gnt_onehot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        sel0 = REQ_IN0[i*BW +: BW];
        sel1 = REQ_IN1[i*BW +: BW];
      end
      gnt_onehot[i] = (gnt_q == IDW'(i));
    end
    ptr_next = (gnt_q == IDW'(NREQ-1)) ? '0 : gnt_q + IDW'(1);
  end

`ifdef OPSCHED_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  assign expire = (state_q != IDLE) && (cnt_q == TMO_LAST);

  always_comb begin
    cnt_d = (state_q == IDLE) ? '0 : cnt_q + 8'd1;
    err_d = expire && !((state_q == WAIT_HIGH) && OP_RD);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign expire = 1'b0;
  assign ERR    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ack_d   = '0;
    res_d   = res_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    st_d    = st_q;
    in0_d   = in0_q;
    in1_d   = in1_q;
    case (state_q)
      IDLE: begin
        if (found && OP_RD) begin
          in0_d   = sel0;
          in1_d   = sel1;
          gnt_d   = win_id;
          st_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        // RD still high here only means the unit has not started yet.
        if (expire) begin
          st_d    = 1'b0;
          res_d   = '0;
          ack_d   = gnt_onehot;
          busy_d  = 1'b0;
          ptr_d   = ptr_next;
          state_d = IDLE;
        end else if (!OP_RD) begin
          st_d    = 1'b0;
          state_d = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (OP_RD) begin
          res_d   = OP_RES;
          ack_d   = gnt_onehot;
          busy_d  = 1'b0;
          ptr_d   = ptr_next;
          state_d = IDLE;
        end else if (expire) begin
          st_d    = 1'b0;
          res_d   = '0;
          ack_d   = gnt_onehot;
          busy_d  = 1'b0;
          ptr_d   = ptr_next;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ack_q   <= '0;
      res_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      st_q    <= 1'b0;
      in0_q   <= '0;
      in1_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      res_q   <= res_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      st_q    <= st_d;
      in0_q   <= in0_d;
      in1_q   <= in1_d;
    end
  end

  assign ACK     = ack_q;
  assign RES_OUT = res_q;
  assign GNT_ID  = gnt_q;
  assign BUSY    = busy_q;
  assign OP_ST   = st_q;
  assign OP_IN0  = in0_q;
  assign OP_IN1  = in1_q;

endmodule

// File: tb/tb_operation_sched.sv
// Scoreboard bench for operation_sched with a behavioural operation unit model.
module tb_operation_sched;

  localparam int BW   = 16;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                CLK = 1'b0;
  logic                RST;
  logic [NREQ-1:0]     req;
  logic [NREQ*BW-1:0]  req_in0, req_in1;
  logic [NREQ-1:0]     ACK;
  logic [BW-1:0]       RES_OUT;
  logic [IDW-1:0]      GNT_ID;
  logic                BUSY, ERR, OP_ST;
  logic [BW-1:0]       OP_IN0, OP_IN1;
  logic                u_rd = 1'b1;
  logic [BW-1:0]       u_res = '0;

  operation_sched #(.BW(BW), .NREQ(NREQ), .IDW(IDW), .TMO(8)) dut (
    .CLK(CLK), .RST(RST), .REQ(req), .REQ_IN0(req_in0), .REQ_IN1(req_in1),
    .ACK(ACK), .RES_OUT(RES_OUT), .GNT_ID(GNT_ID), .BUSY(BUSY), .ERR(ERR),
    .OP_ST(OP_ST), .OP_IN0(OP_IN0), .OP_IN1(OP_IN1), .OP_RD(u_rd), .OP_RES(u_res)
  );

  always #5 CLK = ~CLK;

  function automatic logic [BW-1:0] unit_fn(input logic [BW-1:0] a, input logic [BW-1:0] b);
    return a & (b ^ 16'hFFF0);
  endfunction

  // Unit model: RD falls one edge after seeing ST rise, stays low u_lat cycles.
  int   u_lat   = 2;
  int   u_cnt   = 0;
  bit   u_stuck = 1'b0;
  logic st_prev = 1'b0;

  always @(posedge CLK) begin
    st_prev <= OP_ST;
    if (!u_stuck) begin
      if (u_rd && OP_ST && !st_prev) begin
        u_rd  <= 1'b0;
        u_cnt <= u_lat - 1;
        u_res <= unit_fn(OP_IN0, OP_IN1);
      end else if (!u_rd) begin
        if (u_cnt == 0) u_rd <= 1'b1;
        else            u_cnt <= u_cnt - 1;
      end
    end
  end

  typedef struct {
    int          id;
    logic [15:0] res;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   st_cnt   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input int id, input int at_cyc, input bit err);
    exp_t e;
    e.id  = id;
    e.res = err ? 16'h0000 : unit_fn(req_in0[id*BW +: BW], req_in1[id*BW +: BW]);
    e.err = err;
    e.cyc = at_cyc;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    if (OP_ST) st_cnt++;
    if (ACK != '0) begin
      check_eq("ack_onehot", 32'($onehot(ACK)), 32'd1);
      if (sb.size() == 0) begin
        check_eq("unexpected_ack", 32'(ACK), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("ack_vec", 32'(ACK), 32'd1 << e.id);
        check_eq("gnt_id", 32'(GNT_ID), 32'(e.id));
        check_eq("res_out", 32'(RES_OUT), 32'(e.res));
        check_eq("err", 32'(ERR), 32'(e.err));
        if (e.cyc >= 0) check_eq("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
      req = req & ~ACK;
    end
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && sb.size() > 0; k++) tick();
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int  e0;
    int  blocked;
    bit  rd_before;

    RST = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      req_in0[i*BW +: BW] = 16'($urandom);
      req_in1[i*BW +: BW] = 16'($urandom);
    end

    // Reset holds everything at zero despite pending requests
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("rst_st", 32'(OP_ST), 32'd0);
    end
    check_eq("rst_ack", 32'(ACK), 32'd0);
    check_eq("rst_res", 32'(RES_OUT), 32'd0);
    check_eq("rst_gnt", 32'(GNT_ID), 32'd0);
    check_eq("rst_busy", 32'(BUSY), 32'd0);
    check_eq("rst_err", 32'(ERR), 32'd0);
    check_eq("rst_in0", 32'(OP_IN0), 32'd0);
    check_eq("rst_in1", 32'(OP_IN1), 32'd0);

    // Fairness: all four requesting, served 0,1,2,3 five cycles apart
    e0 = cyc + 1;
    for (int i = 0; i < NREQ; i++) push_exp(i, e0 + 4 + 5*i, 1'b0);
    RST = 1'b1;
    tick();
    check_eq("first_st", 32'(OP_ST), 32'd1);
    check_eq("first_gnt", 32'(GNT_ID), 32'd0);
    check_eq("first_busy", 32'(BUSY), 32'd1);
    check_eq("first_in0", 32'(OP_IN0), 32'(req_in0[0 +: BW]));
    check_eq("first_in1", 32'(OP_IN1), 32'(req_in1[0 +: BW]));
    drain(40);

    // Partial set 1011 from pointer 0 -> 0,1,3
    req = 4'b1011;
    e0  = cyc + 1;
    push_exp(0, e0 + 4, 1'b0);
    push_exp(1, e0 + 9, 1'b0);
    push_exp(3, e0 + 14, 1'b0);
    drain(30);
    tick();
    tick();
    check_eq("res_hold", 32'(RES_OUT), 32'(unit_fn(req_in0[3*BW +: BW], req_in1[3*BW +: BW])));
    check_eq("ack_idle", 32'(ACK), 32'd0);
    check_eq("busy_idle", 32'(BUSY), 32'd0);

    // Single request on requester 2
    req_in0[2*BW +: BW] = 16'h1234;
    req_in1[2*BW +: BW] = 16'h5678;
    req    = 4'b0100;
    e0     = cyc + 1;
    push_exp(2, e0 + 4, 1'b0);
    st_cnt = 0;
    tick();
    check_eq("single_in0", 32'(OP_IN0), 32'h1234);
    check_eq("single_in1", 32'(OP_IN1), 32'h5678);
    check_eq("single_gnt", 32'(GNT_ID), 32'd2);
    drain(20);
    check_eq("st_high_cycles", 32'(st_cnt), 32'd2);

    // Reset during WAIT_HIGH with a slow unit; no grant until RD returns high
    u_lat = 6;
    req   = 4'b0001;
    tick();
    check_eq("mid_grant", 32'(OP_ST), 32'd1);
    tick();
    tick();
    tick();
    check_eq("mid_busy", 32'(BUSY), 32'd1);
    check_eq("mid_st", 32'(OP_ST), 32'd0);
    check_eq("mid_rd_low", 32'(u_rd), 32'd0);
    RST = 1'b0;
    #1;
    check_eq("arst_busy", 32'(BUSY), 32'd0);
    check_eq("arst_gnt", 32'(GNT_ID), 32'd0);
    check_eq("arst_in0", 32'(OP_IN0), 32'd0);
    tick();
    check_eq("arst_ack", 32'(ACK), 32'd0);
    RST     = 1'b1;
    blocked = 0;
    for (int k = 0; k < 20; k++) begin
      rd_before = u_rd;
      tick();
      check_eq("idle_gate", 32'(OP_ST), 32'(rd_before));
      if (!rd_before) blocked++;
      if (OP_ST) break;
    end
    check_eq("regrant", 32'(OP_ST), 32'd1);
    check_eq("blocked_cycles", 32'(blocked), 32'd3);
    check_eq("regrant_gnt", 32'(GNT_ID), 32'd0);
    push_exp(0, cyc + 2 + 6, 1'b0);
    drain(20);
    u_lat = 2;

    // Unit stuck with RD high
    u_stuck = 1'b1;
`ifdef OPSCHED_TIMEOUT_EN
    req = 4'b0110;
    e0  = cyc + 1;
    push_exp(1, e0 + 8, 1'b1);
    push_exp(2, e0 + 17, 1'b1);
    drain(40);
    tick();
    check_eq("tmo_err_clear", 32'(ERR), 32'd0);
`else
    req = 4'b0010;
    tick();
    check_eq("stuck_gnt", 32'(GNT_ID), 32'd1);
    for (int k = 0; k < 30; k++) begin
      tick();
      check_eq("stuck_busy", 32'(BUSY), 32'd1);
      check_eq("stuck_err", 32'(ERR), 32'd0);
    end
    check_eq("stuck_st", 32'(OP_ST), 32'd1);
`endif

    check_eq("sb_final", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
